// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with the ID/EX register, forwarding muxes, ALU and EX/MEM register.
module ex_stage #(
  parameter int WIDTH   = 32,
  parameter int REGBITS = 5
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid_i,
  input  logic [WIDTH-1:0]   id_rd1_i,
  input  logic [WIDTH-1:0]   id_rd2_i,
  input  logic [WIDTH-1:0]   id_imm_i,
  input  logic [REGBITS-1:0] id_rs_i,
  input  logic [REGBITS-1:0] id_rt_i,
  input  logic [REGBITS-1:0] id_rd_i,
  input  logic               id_regwrite_i,
  input  logic               id_memtoreg_i,
  input  logic               id_memwrite_i,
  input  logic               id_alusrc_i,
  input  logic               id_regdst_i,
  input  logic [2:0]         id_alucontrol_i,
  input  logic [1:0]         fwd_a_i,
  input  logic [1:0]         fwd_b_i,
  input  logic [WIDTH-1:0]   wb_result_i,
  output logic [REGBITS-1:0] idex_src1_o,
  output logic [REGBITS-1:0] idex_src2_o,
  output logic               idex_memtoreg_o,
  output logic [REGBITS-1:0] idex_dest_o,
  output logic               exmem_valid_o,
  output logic               exmem_regwrite_o,
  output logic               exmem_memtoreg_o,
  output logic               exmem_memwrite_o,
  output logic [WIDTH-1:0]   exmem_aluout_o,
  output logic [WIDTH-1:0]   exmem_writedata_o,
  output logic [REGBITS-1:0] exmem_dest_o,
  output logic               exmem_zero_o
);
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               alusrc;
    logic               regdst;
    logic [2:0]         alucontrol;
    logic [WIDTH-1:0]   rd1;
    logic [WIDTH-1:0]   rd2;
    logic [WIDTH-1:0]   imm;
    logic [REGBITS-1:0] rs;
    logic [REGBITS-1:0] rt;
    logic [REGBITS-1:0] rd;
  } idex_t;
  typedef struct packed {
    logic               valid;
    logic               regwrite;
    logic               memtoreg;
    logic               memwrite;
    logic               zero;
    logic [WIDTH-1:0]   aluout;
    logic [WIDTH-1:0]   writedata;
    logic [REGBITS-1:0] dest;
  } exmem_t;
  idex_t idex_q, idex_d, id_in;
  exmem_t exmem_q, exmem_d, ex_out;
  logic [WIDTH-1:0] op_a, op_b, alu_b, alu_y;
  logic [REGBITS-1:0] dest;
  always_comb begin
    id_in = '{valid: id_valid_i, regwrite: id_regwrite_i & id_valid_i,
              memtoreg: id_memtoreg_i & id_valid_i, memwrite: id_memwrite_i & id_valid_i,
              alusrc: id_alusrc_i, regdst: id_regdst_i, alucontrol: id_alucontrol_i,
              rd1: id_rd1_i, rd2: id_rd2_i, imm: id_imm_i,
              rs: id_rs_i, rt: id_rt_i, rd: id_rd_i};
    // flush outranks stall so a killed instruction never lingers in EX
    idex_d = flush_i ? '0 : stall_i ? idex_q : id_in;
  end
  always_comb begin
    op_a  = fwd_a_i == 2'd1 ? exmem_q.aluout : fwd_a_i == 2'd2 ? wb_result_i : idex_q.rd1;
    op_b  = fwd_b_i == 2'd1 ? exmem_q.aluout : fwd_b_i == 2'd2 ? wb_result_i : idex_q.rd2;
    alu_b = idex_q.alusrc ? idex_q.imm : op_b;
    alu_y = idex_q.alucontrol == 3'b000 ? op_a & alu_b :
            idex_q.alucontrol == 3'b001 ? op_a | alu_b :
            idex_q.alucontrol == 3'b010 ? op_a + alu_b :
            idex_q.alucontrol == 3'b110 ? op_a - alu_b :
            idex_q.alucontrol == 3'b111 ? {{(WIDTH-1){1'b0}}, $signed(op_a) < $signed(alu_b)} :
            '0;
    dest  = idex_q.regdst ? idex_q.rd : idex_q.rt;
    ex_out = '{valid: idex_q.valid, regwrite: idex_q.regwrite, memtoreg: idex_q.memtoreg,
               memwrite: idex_q.memwrite, zero: alu_y == '0, aluout: alu_y,
               writedata: op_b, dest: dest};
    // a held instruction must reach MEM only once, so stalled cycles emit bubbles
    exmem_d = stall_i ? '0 : ex_out;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idex_q  <= '0;
      exmem_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
    end
  end
  assign idex_src1_o       = idex_q.rs;
  assign idex_src2_o       = idex_q.rt;
  assign idex_memtoreg_o   = idex_q.memtoreg;
  assign idex_dest_o       = idex_q.regdst ? idex_q.rd : idex_q.rt;
  assign exmem_valid_o     = exmem_q.valid;
  assign exmem_regwrite_o  = exmem_q.regwrite;
  assign exmem_memtoreg_o  = exmem_q.memtoreg;
  assign exmem_memwrite_o  = exmem_q.memwrite;
  assign exmem_aluout_o    = exmem_q.aluout;
  assign exmem_writedata_o = exmem_q.writedata;
  assign exmem_dest_o      = exmem_q.dest;
  assign exmem_zero_o      = exmem_q.zero;
endmodule
